alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the 4-bit combinational ALU: WIDTH-bit AND/OR/ADD/SUB/SLT plus

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_seq.sv | 115 +++++++++++
 tb/tb_alu_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
// The opcode layout is {add_sub, op[1:0]}, so SUB and SLT both have bit 2 set.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU: AND/OR/ADD/SUB/SLT/SLL/SRL with carry and overflow flags.
// MUL is not handled here and returns zero with clear flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] f,
  output logic             carry,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [CNT_W-2:0] amt;

  // One shared adder: bit 2 of op selects a + ~b + 1, which serves SUB and SLT.
  assign b_eff = op[2] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[2]};
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  assign amt   = b[CNT_W-2:0];

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    f        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND: f = a & b;
      OP_OR:  f = a | b;
      OP_ADD, OP_SUB: begin
        f        = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = ovf;
      end
      // Sign of the difference corrected by overflow gives a true signed compare.
      OP_SLT: f = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      OP_SLL: f = (int'(amt) >= WIDTH) ? '0 : (a << amt);
      OP_SRL: f = (int'(amt) >= WIDTH) ? '0 : (a >> amt);
      default: f = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: single-cycle ops via alu_core, shift-add MUL over WIDTH cycles.
// The result and flags are held on the output port until out_ready consumes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, mul_last;

  logic [WIDTH-1:0]   core_f;
  logic               core_carry, core_ovf;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .f        (core_f),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign mul_last  = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (op == OP_MUL) ? S_MUL : S_HOLD;
      end
      S_MUL: begin
        if (mul_last) state_d = S_HOLD;
      end
      S_HOLD: begin
        // Consuming the result frees the port for a new op in the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (!in_valid)           state_d = S_IDLE;
          else if (op == OP_MUL)   state_d = S_MUL;
          else                     state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      f        <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      if (op != OP_MUL) begin
        f        <= core_f;
        zero     <= (core_f == '0);
        carry    <= core_carry;
        overflow <= core_ovf;
      end
    end else if (state_q == S_MUL) begin
      // One multiplier bit per cycle, LSB first; the multiplicand walks left.
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (mul_last) begin
        f        <= acc_nxt[WIDTH-1:0];
        zero     <= (acc_nxt[WIDTH-1:0] == '0);
        carry    <= 1'b0;
        overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed corner sequences, a constant vector
// table and a strided/random sweep, all scored through an in-order expected-result queue.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic       z;
    logic       c;
    logic       v;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] f;
  logic       zero, carry, overflow;

  logic       bp_en = 1'b0;
  logic       or_manual = 1'b1;

  int errors = 0;
  int checks = 0;
  vec_t sb[$];
  vec_t tbl[16];

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_ready = bp_en ? ($urandom_range(0, 3) != 0) : or_manual;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    vec_t r;
    int   s, sx, sy;
    logic [7:0] t;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r = '{op: o, a: x, b: y, f: 8'h00, z: 1'b0, c: 1'b0, v: 1'b0};
    case (o)
      OP_AND: r.f = x & y;
      OP_OR:  r.f = x | y;
      OP_ADD: begin
        s = int'(x) + int'(y);
        r.f = s[7:0];
        r.c = (s > 255);
        r.v = (sx + sy > 127) || (sx + sy < -128);
      end
      OP_SUB: begin
        s = int'(x) - int'(y);
        r.f = s[7:0];
        r.c = (x >= y);
        r.v = (sx - sy > 127) || (sx - sy < -128);
      end
      OP_SLT: r.f = (sx < sy) ? 8'd1 : 8'd0;
      OP_SLL: begin t = x << y[2:0]; r.f = t; end
      OP_SRL: begin t = x >> y[2:0]; r.f = t; end
      default: begin
        s = int'(x) * int'(y);
        r.f = s[7:0];
        r.v = (s > 255);
      end
    endcase
    r.z = (r.f == 8'h00);
    return r;
  endfunction

  // Presents one op and holds it until in_ready is seen; returns one tick after the accepting edge.
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input vec_t e);
    int n = 0;
    logic got = 1'b0;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    while (!got && n < 200) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", 32'(got), 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    idle();
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        vec_t e;
        e = sb.pop_front();
        check($sformatf("result op=%0d a=%0h b=%0h {f,z,c,v}", e.op, e.a, e.b),
              32'({f, zero, carry, overflow}), 32'({e.f, e.z, e.c, e.v}));
      end
    end
  end

  initial begin
    tbl[0]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_OR,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{OP_ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{OP_SLT, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{OP_SLT, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_SLT, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{OP_SLL, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{OP_SLL, 8'h01, 8'h0F, 8'h80, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_SRL, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{OP_SRL, 8'h0F, 8'h0C, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{OP_MUL, 8'h00, 8'h37, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{OP_MUL, 8'h10, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst {f,z,c,v}", 32'({f, zero, carry, overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD overflow: result visible one cycle after accept
    do_op(OP_ADD, 8'h7F, 8'h01, model(OP_ADD, 8'h7F, 8'h01));
    idle();
    check("add7f out_valid", 32'(out_valid), 32'd1);
    check("add7f {f,z,c,v}", 32'({f, zero, carry, overflow}), 32'({8'h80, 1'b0, 1'b0, 1'b1}));
    do_op(OP_SUB, 8'h05, 8'h05, model(OP_SUB, 8'h05, 8'h05));
    idle();
    check("sub55 {f,z,c,v}", 32'({f, zero, carry, overflow}), 32'({8'h00, 1'b1, 1'b1, 1'b0}));
    do_op(OP_SLT, 8'h80, 8'h01, model(OP_SLT, 8'h80, 8'h01));
    idle();
    check("slt80 f", 32'(f), 32'h01);
    wait_drain();

    // MUL latency, then held result under backpressure, then same-cycle hand-off
    or_manual = 1'b0;
    do_op(OP_MUL, 8'd20, 8'd13, model(OP_MUL, 8'd20, 8'd13));
    idle();
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("mul busy c%0d {in_ready,out_valid}", i), 32'({in_ready, out_valid}), 32'd0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mul hold c%0d {ov,ir,f,v}", i),
            32'({out_valid, in_ready, f, overflow}), 32'({1'b1, 1'b0, 8'h04, 1'b1}));
      @(posedge clk);
      #1;
    end
    or_manual = 1'b1;
    do_op(OP_OR, 8'hF0, 8'h0F, model(OP_OR, 8'hF0, 8'h0F));
    idle();
    check("b2b or {ov,f}", 32'({out_valid, f}), 32'({1'b1, 8'hFF}));
    wait_drain();

    // Async reset in the middle of a MUL discards it
    do_op(OP_MUL, 8'd15, 8'd15, model(OP_MUL, 8'd15, 8'd15));
    idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midmul rst {ov,f}", 32'({out_valid, f}), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(OP_ADD, 8'd3, 8'd4, model(OP_ADD, 8'd3, 8'd4));
    idle();
    check("post rst add f", 32'(f), 32'd7);
    wait_drain();

    // Constant vector table under random backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 16; i++) do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i]);
    wait_drain();

    // Strided sweep of single-cycle ops including both operand extremes
    for (int x = 0; x < 256; x += 5) begin
      for (int y = 0; y < 256; y += 17) begin
        do_op(OP_AND, 8'(x), 8'(y), model(OP_AND, 8'(x), 8'(y)));
        do_op(OP_OR,  8'(x), 8'(y), model(OP_OR,  8'(x), 8'(y)));
        do_op(OP_ADD, 8'(x), 8'(y), model(OP_ADD, 8'(x), 8'(y)));
        do_op(OP_SUB, 8'(x), 8'(y), model(OP_SUB, 8'(x), 8'(y)));
        do_op(OP_SLT, 8'(x), 8'(y), model(OP_SLT, 8'(x), 8'(y)));
      end
    end

    // Random mix of all opcodes, MUL included
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro;
      logic [7:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op(ro, ra, rb, model(ro, ra, rb));
    end
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
